id_ex_operand_stage: RTL

ID/EX pipeline stage for the pipelined RV32 core. It sits directly upstream of the ALU. It registers decoded instruction fields and control bits, and resolves EX/MEM and MEM/WB forwarding. It drives the ALU's `SrcA`, `SrcB` and `aluc`. It also detects load-use hazards, inserts bubbles, and honours external stall and flush requests from the hazard/branch logic.

---
 rtl/id_ex_operand_stage.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register for the RV32 core: latches decoded fields, resolves
// EX/MEM and MEM/WB forwarding into ALU operands, and handles bubbles/holds.
module id_ex_operand_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic            id_uses_rs1,
  input  logic            id_uses_rs2,
  input  logic [3:0]      id_aluc,
  input  logic            id_alusrc_a,
  input  logic            id_alusrc_b,
  input  logic            id_regwrite,
  input  logic            id_memread,
  input  logic            id_memwrite,
  input  logic            exmem_regwrite,
  input  logic [4:0]      exmem_rd,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_regwrite,
  input  logic [4:0]      memwb_rd,
  input  logic [XLEN-1:0] memwb_result,
  output logic [XLEN-1:0] SrcA,
  output logic [XLEN-1:0] SrcB,
  output logic [3:0]      aluc,
  output logic            ex_valid,
  output logic            ex_regwrite,
  output logic            ex_memread,
  output logic            ex_memwrite,
  output logic [4:0]      ex_rd,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_store_data,
  output logic            id_hold
);

  logic            valid_q,    valid_d;
  logic [XLEN-1:0] pc_q,       pc_d;
  logic [XLEN-1:0] rs1_data_q, rs1_data_d;
  logic [XLEN-1:0] rs2_data_q, rs2_data_d;
  logic [XLEN-1:0] imm_q,      imm_d;
  logic [4:0]      rs1_q,      rs1_d;
  logic [4:0]      rs2_q,      rs2_d;
  logic [4:0]      rd_q,       rd_d;
  logic [3:0]      aluc_q,     aluc_d;
  logic            alusrc_a_q, alusrc_a_d;
  logic            alusrc_b_q, alusrc_b_d;
  logic            regwrite_q, regwrite_d;
  logic            memread_q,  memread_d;
  logic            memwrite_q, memwrite_d;

  logic [XLEN-1:0] fwd1, fwd2;
  logic            load_use;

  // x0 never forwards; EX/MEM is younger than MEM/WB so it wins.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [4:0]      idx,
    input logic [XLEN-1:0] reg_data,
    input logic            em_we,
    input logic [4:0]      em_rd,
    input logic [XLEN-1:0] em_res,
    input logic            mw_we,
    input logic [4:0]      mw_rd,
    input logic [XLEN-1:0] mw_res
  );
    if (idx == 5'd0)                 return '0;
    else if (em_we && em_rd == idx)  return em_res;
    else if (mw_we && mw_rd == idx)  return mw_res;
    else                             return reg_data;
  endfunction

  always_comb begin
    fwd1 = fwd_sel(rs1_q, rs1_data_q, exmem_regwrite, exmem_rd, exmem_result,
                   memwb_regwrite, memwb_rd, memwb_result);
    fwd2 = fwd_sel(rs2_q, rs2_data_q, exmem_regwrite, exmem_rd, exmem_result,
                   memwb_regwrite, memwb_rd, memwb_result);
  end

  assign load_use = id_valid && valid_q && memread_q && (rd_q != 5'd0) &&
                    ((id_uses_rs1 && id_rs1 == rd_q) ||
                     (id_uses_rs2 && id_rs2 == rd_q));

  assign id_hold = (stall || load_use) && !flush;

  // Operand-usage flags are only needed for the hazard check in ID, so they
  // are not carried into EX.
  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    aluc_d     = aluc_q;
    alusrc_a_d = alusrc_a_q;
    alusrc_b_d = alusrc_b_q;
    regwrite_d = regwrite_q;
    memread_d  = memread_q;
    memwrite_d = memwrite_q;
    if (flush || (!stall && load_use)) begin
      valid_d    = 1'b0;
      pc_d       = '0;
      rs1_data_d = '0;
      rs2_data_d = '0;
      imm_d      = '0;
      rs1_d      = 5'd0;
      rs2_d      = 5'd0;
      rd_d       = 5'd0;
      aluc_d     = 4'b0000;
      alusrc_a_d = 1'b0;
      alusrc_b_d = 1'b0;
      regwrite_d = 1'b0;
      memread_d  = 1'b0;
      memwrite_d = 1'b0;
    end else if (stall) begin
      // Capture forwarded operands so they survive the producer retiring.
      rs1_data_d = fwd1;
      rs2_data_d = fwd2;
    end else begin
      valid_d    = id_valid;
      pc_d       = id_pc;
      rs1_data_d = id_rs1_data;
      rs2_data_d = id_rs2_data;
      imm_d      = id_imm;
      rs1_d      = id_rs1;
      rs2_d      = id_rs2;
      rd_d       = id_rd;
      aluc_d     = id_aluc;
      alusrc_a_d = id_alusrc_a;
      alusrc_b_d = id_alusrc_b;
      regwrite_d = id_regwrite && id_valid;
      memread_d  = id_memread  && id_valid;
      memwrite_d = id_memwrite && id_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= 5'd0;
      rs2_q      <= 5'd0;
      rd_q       <= 5'd0;
      aluc_q     <= 4'b0000;
      alusrc_a_q <= 1'b0;
      alusrc_b_q <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      aluc_q     <= aluc_d;
      alusrc_a_q <= alusrc_a_d;
      alusrc_b_q <= alusrc_b_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
    end
  end

  assign SrcA          = alusrc_a_q ? pc_q  : fwd1;
  assign SrcB          = alusrc_b_q ? imm_q : fwd2;
  assign ex_store_data = fwd2;
  assign aluc          = aluc_q;
  assign ex_valid      = valid_q;
  assign ex_regwrite   = regwrite_q;
  assign ex_memread    = memread_q;
  assign ex_memwrite   = memwrite_q;
  assign ex_rd         = rd_q;
  assign ex_pc         = pc_q;

endmodule
